// File: rtl/mode2_pkg.sv
// Shared types and defaults for LED display mode 2 (progressive fill, then drain).
package mode2_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   localparam int LED_WIDTH    = 8;
   localparam int STEP_DIV_DEF = 1;

   // Prescaler counter width; a divide-by-1 still needs one bit to declare.
   function automatic int cnt_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/mode2_step_tick.sv
// Step prescaler: emits one tick every STEP_DIV enabled cycles; en=0 freezes the count.
module mode2_step_tick
   import mode2_pkg::*;
#(
   parameter int STEP_DIV = STEP_DIV_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int            CW   = cnt_width(STEP_DIV);
   localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mode2_ledsangdan_tatdan.sv
// LED mode 2: fill LEDs one per step until all on, then clear them in the same order.
// Optional 1-clk done pulse per full cycle when MODE2_DONE_PULSE_EN is defined.
//
// state | meaning
// FILL  | each tick shifts a 1 in; moves to DRAIN when OUT becomes all-ones
// DRAIN | each tick shifts a 0 in; moves to FILL when OUT becomes zero
module mode2_ledsangdan_tatdan
   import mode2_pkg::*;
#(
   parameter int WIDTH     = LED_WIDTH,
   parameter int STEP_DIV  = STEP_DIV_DEF,
   parameter int MSB_FIRST = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
`ifdef MODE2_DONE_PULSE_EN
   output logic             done,
`endif
   output logic [WIDTH-1:0] OUT
);

   state_t           state_q;
   state_t           state_nxt;
   logic [WIDTH-1:0] out_nxt;
   logic [WIDTH-1:0] shifted;
   logic             fill_bit;
   logic             tick;

   mode2_step_tick #(
      .STEP_DIV (STEP_DIV)
   ) u_step_tick (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FILL;
         OUT     <= '0;
      end else begin
         state_q <= state_nxt;
         OUT     <= out_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         FILL:    if (tick && (&out_nxt))       state_nxt = DRAIN;
         DRAIN:   if (tick && (out_nxt == '0)) state_nxt = FILL;
         default:                               state_nxt = FILL;
      endcase
   end

   // Shift direction is fixed by MSB_FIRST; the inserted bit is 1 while filling.
   always_comb begin
      fill_bit = (state_q == FILL);
      shifted  = (MSB_FIRST != 0) ? {fill_bit, OUT[WIDTH-1:1]}
                                  : {OUT[WIDTH-2:0], fill_bit};
      out_nxt  = OUT;
      case (state_q)
         FILL, DRAIN: if (tick) out_nxt = shifted;
         default:               out_nxt = '0;
      endcase
   end

`ifdef MODE2_DONE_PULSE_EN
   logic done_nxt;

   assign done_nxt = tick && (state_q == DRAIN) && (out_nxt == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done <= 1'b0;
      end else begin
         done <= done_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_mode2_ledsangdan_tatdan.sv
// Bench for LED mode 2: three parameterisations driven in lockstep against a step-index model.
module tb_mode2_ledsangdan_tatdan;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic       en    = 1'b0;
   logic [7:0] out0, out1, out2;
`ifdef MODE2_DONE_PULSE_EN
   logic       done0, done1, done2;
`endif

   always #5 clk = ~clk;

   mode2_ledsangdan_tatdan #(.WIDTH(8), .STEP_DIV(1), .MSB_FIRST(0)) dut0 (
      .clk(clk), .reset(reset), .en(en),
`ifdef MODE2_DONE_PULSE_EN
      .done(done0),
`endif
      .OUT(out0));

   mode2_ledsangdan_tatdan #(.WIDTH(8), .STEP_DIV(4), .MSB_FIRST(0)) dut1 (
      .clk(clk), .reset(reset), .en(en),
`ifdef MODE2_DONE_PULSE_EN
      .done(done1),
`endif
      .OUT(out1));

   mode2_ledsangdan_tatdan #(.WIDTH(8), .STEP_DIV(1), .MSB_FIRST(1)) dut2 (
      .clk(clk), .reset(reset), .en(en),
`ifdef MODE2_DONE_PULSE_EN
      .done(done2),
`endif
      .OUT(out2));

   int errors = 0;
   int checks = 0;

   // Model: pattern position k in 0..15 plus prescaler phase p, per instance.
   int k[3];
   int p[3];
   int divs[3] = '{1, 4, 1};
   bit msbs[3] = '{1'b0, 1'b0, 1'b1};
   bit done_exp;

   typedef struct {
      logic       en;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[20];
   logic [7:0] seq[20] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                           8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00,
                           8'h01, 8'h03, 8'h07, 8'h0F};

   function automatic logic [7:0] pat(input int kk, input bit msb);
      int         m;
      logic [7:0] v, r;
      if (kk <= 8) m = (1 << kk) - 1;
      else         m = 255 & ~((1 << (kk - 8)) - 1);
      v = m[7:0];
      r = v;
      if (msb) for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      done_exp = 1'b0;
      if (reset && en) begin
         for (int i = 0; i < 3; i++) begin
            p[i]++;
            if (p[i] == divs[i]) begin
               p[i] = 0;
               if (i == 0 && k[i] == 15) done_exp = 1'b1;
               k[i] = (k[i] + 1) % 16;
            end
         end
      end
   endtask

   task automatic check_all();
      chk("out0_model", out0, pat(k[0], msbs[0]));
      chk("out1_model", out1, pat(k[1], msbs[1]));
      chk("out2_model", out2, pat(k[2], msbs[2]));
`ifdef MODE2_DONE_PULSE_EN
      chk("done0_model", {7'b0, done0}, {7'b0, done_exp});
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         k[i] = 0;
         p[i] = 0;
      end
      done_exp = 1'b0;
      check_all();
      @(posedge clk);
      #1;
      check_all();
      reset = 1'b1;
   endtask

   initial begin
      int n;
      for (int i = 0; i < 20; i++) tbl[i] = '{1'b1, seq[i]};

      // Reset state and full cycle from reset
      do_reset();
      for (int i = 0; i < 20; i++) begin
         en = tbl[i].en;
         step();
         chk("tbl_out0", out0, tbl[i].exp);
      end

      // Pause at 1F, resume to 3F
      n = 0;
      while (out0 !== 8'h1F && n < 20) begin
         step();
         n++;
      end
      chk("pause_reach_1f", out0, 8'h1F);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("pause_hold", out0, 8'h1F);
      end
      en = 1'b1;
      step();
      chk("pause_resume", out0, 8'h3F);

      // Prescaler with mid-count pause, and mirror start after async reset
      #2;
      do_reset();
      en = 1'b1;
      step();
      chk("mirror_first", out2, 8'h80);
      chk("div4_wait1", out1, 8'h00);
      step();
      chk("div4_wait2", out1, 8'h00);
      step();
      chk("div4_wait3", out1, 8'h00);
      step();
      chk("div4_tick1", out1, 8'h01);
      step();
      step();
      en = 1'b0;
      step();
      step();
      chk("div4_paused", out1, 8'h01);
      en = 1'b1;
      step();
      chk("div4_resume_wait", out1, 8'h01);
      step();
      chk("div4_tick2", out1, 8'h03);

      // Random enable with occasional asynchronous mid-cycle reset
      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(3) != 0);
         if ($urandom_range(99) == 0) begin
            #2;
            do_reset();
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
